// File: rtl/pool_mem_port_sched.sv
// -----------------------------------------------------------------------------
// pool_mem_port_sched
//
// Time-shares the two ports of the layer-2 pool memory between the layer's own
// pool units (writer) and the next layer's feature fetch (reader). Ownership is
// sequenced once per frame:
//   IDLE -> WRITE (start) -> DRAIN (wr_done) -> READY (after DRAIN_CYCLES)
//        -> READ (rd_req) -> IDLE (rd_release)
// The memory-side port mux is registered (one cycle of latency). An enable
// raised by a requester that does not currently own the memory is blocked and
// latches the sticky err_collide flag.
//
// Optional feature, macro POOL_ARB_TIMEOUT_EN:
//   defined   - watchdog forces READ back to IDLE after TIMEOUT_CYCLES cycles
//               without rd_release and latches err_timeout
//   undefined - READ is held indefinitely and o_err_timeout is tied 0
//
// Parameters:
//   POOL_ADDR_WIDTH  pool memory address width
//   DRAIN_CYCLES     settle cycles between wr_done and READY (>= 1)
//   FRAME_CNT_WIDTH  width of the completed-frame counter
//   TIMEOUT_CYCLES   read-ownership watchdog limit (macro build only)
//
// Ports:
//   i_clock                  system clock
//   i_reset                  synchronous, active-high reset
//   i_start                  begin a new frame (writer ownership)
//   o_wr_enable              writer owns the memory
//   i_wr_addr_a/b            writer addresses
//   i_wr_rden_a/b            writer read enables
//   i_wr_wren_a/b            writer write enables
//   i_wr_done                writer finished the frame
//   i_rd_req                 reader requests ownership
//   o_rd_grant               reader owns the memory
//   i_rd_addr_a/b            reader addresses
//   i_rd_rden_a/b            reader read enables
//   i_rd_release             reader finished the frame
//   o_mem_addr_a/b           pool memory address ports
//   o_mem_rden_a/b           pool memory read enables
//   o_mem_wren_a/b           pool memory write enables
//   o_frame_cnt              frames fully released since reset (wraps)
//   o_err_collide            sticky: enable raised by a non-owner
//   o_err_timeout            sticky: watchdog forced a release
// -----------------------------------------------------------------------------
module pool_mem_port_sched #(
  parameter int unsigned POOL_ADDR_WIDTH = 10,
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter int unsigned FRAME_CNT_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  output logic                       o_wr_enable,
  input  logic [POOL_ADDR_WIDTH-1:0] i_wr_addr_a,
  input  logic [POOL_ADDR_WIDTH-1:0] i_wr_addr_b,
  input  logic                       i_wr_rden_a,
  input  logic                       i_wr_rden_b,
  input  logic                       i_wr_wren_a,
  input  logic                       i_wr_wren_b,
  input  logic                       i_wr_done,
  input  logic                       i_rd_req,
  output logic                       o_rd_grant,
  input  logic [POOL_ADDR_WIDTH-1:0] i_rd_addr_a,
  input  logic [POOL_ADDR_WIDTH-1:0] i_rd_addr_b,
  input  logic                       i_rd_rden_a,
  input  logic                       i_rd_rden_b,
  input  logic                       i_rd_release,
  output logic [POOL_ADDR_WIDTH-1:0] o_mem_addr_a,
  output logic [POOL_ADDR_WIDTH-1:0] o_mem_addr_b,
  output logic                       o_mem_rden_a,
  output logic                       o_mem_rden_b,
  output logic                       o_mem_wren_a,
  output logic                       o_mem_wren_b,
  output logic [FRAME_CNT_WIDTH-1:0] o_frame_cnt,
  output logic                       o_err_collide,
  output logic                       o_err_timeout
);

  // Elaboration-time parameter sanity check.
  if (DRAIN_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("pool_mem_port_sched: DRAIN_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_DRAIN = 3'd2,
    S_READY = 3'd3,
    S_READ  = 3'd4
  } state_t;

  // The drain counter only ever holds 0 .. DRAIN_CYCLES-1.
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [DRAIN_W-1:0]         r_drain_cnt;
  logic                       w_drain_last;
  logic                       w_timeout_hit;

  // Registered outputs and their next values.
  logic                       r_wr_enable,  w_wr_enable_d;
  logic                       r_rd_grant,   w_rd_grant_d;
  logic [POOL_ADDR_WIDTH-1:0] r_mem_addr_a, w_mem_addr_a_d;
  logic [POOL_ADDR_WIDTH-1:0] r_mem_addr_b, w_mem_addr_b_d;
  logic                       r_mem_rden_a, w_mem_rden_a_d;
  logic                       r_mem_rden_b, w_mem_rden_b_d;
  logic                       r_mem_wren_a, w_mem_wren_a_d;
  logic                       r_mem_wren_b, w_mem_wren_b_d;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
  logic                       r_err_collide;
  logic                       w_collide;
  logic                       w_frame_inc;

  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

  // ---------------------------------------------------------------------------
  // Read-ownership watchdog
  // ---------------------------------------------------------------------------
`ifdef POOL_ARB_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_err_timeout;

  // Fires on the last permitted READ cycle; a release in that same cycle is a
  // normal release, not a timeout.
  assign w_timeout_hit = (r_state == S_READ) && !i_rd_release && (r_wdog == WDOG_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      // Counts only while READ is kept; any exit clears it.
      if (r_state == S_READ && w_next_state == S_READ) begin
        r_wdog <= r_wdog + 1'b1;
      end else begin
        r_wdog <= '0;
      end
      r_err_timeout <= r_err_timeout | w_timeout_hit;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM process 1: state register (plus the drain counter it depends on)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, exactly like the hardware does.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DRAIN && !w_drain_last) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // Events not listed for a state (start outside IDLE, wr_done outside WRITE,
  // rd_release outside READ) simply fall through and are dropped.
  always_comb begin
    // NOTE: the default assignment ahead of the case keeps every path driven,
    // so no latch is inferred for w_next_state.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start)      w_next_state = S_WRITE;
      S_WRITE: if (i_wr_done)    w_next_state = S_DRAIN;
      S_DRAIN: if (w_drain_last) w_next_state = S_READY;
      S_READY: if (i_rd_req)     w_next_state = S_READ;
      S_READ:  if (i_rd_release || w_timeout_hit) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output decode (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  // Ownership flags decode the next state so they become visible on the same
  // edge that enters the state. The memory mux follows the current state, so
  // mem_* trail the requester's signals by exactly one cycle; only the owner's
  // enables are ever forwarded.
  always_comb begin
    w_wr_enable_d  = (w_next_state == S_WRITE);
    w_rd_grant_d   = (w_next_state == S_READ);
    w_mem_addr_a_d = '0;
    w_mem_addr_b_d = '0;
    w_mem_rden_a_d = 1'b0;
    w_mem_rden_b_d = 1'b0;
    w_mem_wren_a_d = 1'b0;
    w_mem_wren_b_d = 1'b0;
    case (r_state)
      S_WRITE: begin
        w_mem_addr_a_d = i_wr_addr_a;
        w_mem_addr_b_d = i_wr_addr_b;
        w_mem_rden_a_d = i_wr_rden_a;
        w_mem_rden_b_d = i_wr_rden_b;
        w_mem_wren_a_d = i_wr_wren_a;
        w_mem_wren_b_d = i_wr_wren_b;
      end
      S_READ: begin
        w_mem_addr_a_d = i_rd_addr_a;
        w_mem_addr_b_d = i_rd_addr_b;
        w_mem_rden_a_d = i_rd_rden_a;
        w_mem_rden_b_d = i_rd_rden_b;
      end
      default: ;
    endcase
  end

  assign w_collide =
      ((r_state != S_WRITE) && (i_wr_wren_a || i_wr_wren_b || i_wr_rden_a || i_wr_rden_b)) ||
      ((r_state != S_READ)  && (i_rd_rden_a || i_rd_rden_b));

  // A frame counts as completed only on a real release, never on a timeout.
  assign w_frame_inc = (r_state == S_READ) && i_rd_release;

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_enable   <= 1'b0;
      r_rd_grant    <= 1'b0;
      r_mem_addr_a  <= '0;
      r_mem_addr_b  <= '0;
      r_mem_rden_a  <= 1'b0;
      r_mem_rden_b  <= 1'b0;
      r_mem_wren_a  <= 1'b0;
      r_mem_wren_b  <= 1'b0;
      r_frame_cnt   <= '0;
      r_err_collide <= 1'b0;
    end else begin
      r_wr_enable   <= w_wr_enable_d;
      r_rd_grant    <= w_rd_grant_d;
      r_mem_addr_a  <= w_mem_addr_a_d;
      r_mem_addr_b  <= w_mem_addr_b_d;
      r_mem_rden_a  <= w_mem_rden_a_d;
      r_mem_rden_b  <= w_mem_rden_b_d;
      r_mem_wren_a  <= w_mem_wren_a_d;
      r_mem_wren_b  <= w_mem_wren_b_d;
      r_err_collide <= r_err_collide | w_collide;
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign o_wr_enable   = r_wr_enable;
  assign o_rd_grant    = r_rd_grant;
  assign o_mem_addr_a  = r_mem_addr_a;
  assign o_mem_addr_b  = r_mem_addr_b;
  assign o_mem_rden_a  = r_mem_rden_a;
  assign o_mem_rden_b  = r_mem_rden_b;
  assign o_mem_wren_a  = r_mem_wren_a;
  assign o_mem_wren_b  = r_mem_wren_b;
  assign o_frame_cnt   = r_frame_cnt;
  assign o_err_collide = r_err_collide;

endmodule

// File: tb/tb_pool_mem_port_sched.sv
// -----------------------------------------------------------------------------
// tb_pool_mem_port_sched
//
// Directed frame scenarios plus a randomized section, all checked every cycle
// against a frame-ownership reference model; directed points add fixed
// expectations (latency, counts, sticky flags).
// -----------------------------------------------------------------------------
module tb_pool_mem_port_sched;

  localparam int AW  = 10;
  localparam int D   = 3;
  localparam int FW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, wr_done, rd_req, rd_release;
  logic [AW-1:0] wr_addr_a, wr_addr_b, rd_addr_a, rd_addr_b;
  logic          wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b, rd_rden_a, rd_rden_b;

  logic          wr_enable, rd_grant;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic          mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b;
  logic [FW-1:0] frame_cnt;
  logic          err_collide, err_timeout;

  pool_mem_port_sched #(
    .POOL_ADDR_WIDTH(AW),
    .DRAIN_CYCLES   (D),
    .FRAME_CNT_WIDTH(FW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clock      (clk),
    .i_reset      (reset),
    .i_start      (start),
    .o_wr_enable  (wr_enable),
    .i_wr_addr_a  (wr_addr_a),
    .i_wr_addr_b  (wr_addr_b),
    .i_wr_rden_a  (wr_rden_a),
    .i_wr_rden_b  (wr_rden_b),
    .i_wr_wren_a  (wr_wren_a),
    .i_wr_wren_b  (wr_wren_b),
    .i_wr_done    (wr_done),
    .i_rd_req     (rd_req),
    .o_rd_grant   (rd_grant),
    .i_rd_addr_a  (rd_addr_a),
    .i_rd_addr_b  (rd_addr_b),
    .i_rd_rden_a  (rd_rden_a),
    .i_rd_rden_b  (rd_rden_b),
    .i_rd_release (rd_release),
    .o_mem_addr_a (mem_addr_a),
    .o_mem_addr_b (mem_addr_b),
    .o_mem_rden_a (mem_rden_a),
    .o_mem_rden_b (mem_rden_b),
    .o_mem_wren_a (mem_wren_a),
    .o_mem_wren_b (mem_wren_b),
    .o_frame_cnt  (frame_cnt),
    .o_err_collide(err_collide),
    .o_err_timeout(err_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- reference model: who owns the memory ----------------
  typedef enum {PH_IDLE, PH_WRITE, PH_SETTLE, PH_WAIT_RD, PH_READ} phase_e;
  phase_e        ph = PH_IDLE;
  int            settle_n = 0;
  int            read_n   = 0;
  logic          e_wr_enable, e_rd_grant, e_rden_a, e_rden_b, e_wren_a, e_wren_b;
  logic [AW-1:0] e_addr_a, e_addr_b;
  logic [FW-1:0] e_frame;
  logic          e_collide, e_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge worth of the ownership rules to the model.
  task automatic model_update();
    logic any_wr, any_rd;
    any_wr = wr_rden_a | wr_rden_b | wr_wren_a | wr_wren_b;
    any_rd = rd_rden_a | rd_rden_b;
    e_addr_a = '0; e_addr_b = '0;
    e_rden_a = 0;  e_rden_b = 0; e_wren_a = 0; e_wren_b = 0;
    if (reset) begin
      ph = PH_IDLE; settle_n = 0; read_n = 0;
      e_frame = '0; e_collide = 0; e_timeout = 0;
    end else begin
      if (ph == PH_WRITE) begin
        e_addr_a = wr_addr_a; e_addr_b = wr_addr_b;
        e_rden_a = wr_rden_a; e_rden_b = wr_rden_b;
        e_wren_a = wr_wren_a; e_wren_b = wr_wren_b;
      end else if (ph == PH_READ) begin
        e_addr_a = rd_addr_a; e_addr_b = rd_addr_b;
        e_rden_a = rd_rden_a; e_rden_b = rd_rden_b;
      end
      if ((ph != PH_WRITE && any_wr) || (ph != PH_READ && any_rd)) e_collide = 1;
      case (ph)
        PH_IDLE:    if (start) ph = PH_WRITE;
        PH_WRITE:   if (wr_done) begin ph = PH_SETTLE; settle_n = 0; end
        PH_SETTLE:  begin settle_n++; if (settle_n == D) ph = PH_WAIT_RD; end
        PH_WAIT_RD: if (rd_req) begin ph = PH_READ; read_n = 0; end
        PH_READ: begin
          if (rd_release) begin
            ph = PH_IDLE;
            e_frame = e_frame + 1'b1;
          end else begin
            read_n++;
`ifdef POOL_ARB_TIMEOUT_EN
            if (read_n == TMO) begin ph = PH_IDLE; e_timeout = 1; end
`endif
          end
        end
        default: ph = PH_IDLE;
      endcase
    end
    e_wr_enable = (ph == PH_WRITE);
    e_rd_grant  = (ph == PH_READ);
  endtask

  task automatic compare_all();
    check("wr_enable",   32'(wr_enable),   32'(e_wr_enable));
    check("rd_grant",    32'(rd_grant),    32'(e_rd_grant));
    check("mem_addr_a",  32'(mem_addr_a),  32'(e_addr_a));
    check("mem_addr_b",  32'(mem_addr_b),  32'(e_addr_b));
    check("mem_rden_a",  32'(mem_rden_a),  32'(e_rden_a));
    check("mem_rden_b",  32'(mem_rden_b),  32'(e_rden_b));
    check("mem_wren_a",  32'(mem_wren_a),  32'(e_wren_a));
    check("mem_wren_b",  32'(mem_wren_b),  32'(e_wren_b));
    check("frame_cnt",   32'(frame_cnt),   32'(e_frame));
    check("err_collide", 32'(err_collide), 32'(e_collide));
    check("err_timeout", 32'(err_timeout), 32'(e_timeout));
  endtask

  // One clock: DUT and model both consume the current inputs; outputs are
  // compared 1 time unit after the edge. Callers then set the next inputs.
  task automatic step();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    reset = 0; start = 0; wr_done = 0; rd_req = 0; rd_release = 0;
    wr_addr_a = '0; wr_addr_b = '0; rd_addr_a = '0; rd_addr_b = '0;
    wr_rden_a = 0; wr_rden_b = 0; wr_wren_a = 0; wr_wren_b = 0;
    rd_rden_a = 0; rd_rden_b = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int t_done;
    int g;
    logic got;

    // ---------------- reset ----------------
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    check("rst_wr_enable", 32'(wr_enable), 0);
    check("rst_rd_grant",  32'(rd_grant),  0);
    check("rst_mem_wren",  32'({mem_wren_a, mem_wren_b, mem_rden_a, mem_rden_b}), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);

    // ---------------- normal frame ----------------
    start = 1; step(); start = 0;
    check("wr_enable_rise", 32'(wr_enable), 1);
    for (int i = 0; i < 5; i++) begin
      wr_addr_a = AW'(i); wr_wren_a = 1;
      wr_addr_b = AW'($urandom); wr_rden_b = 1'($urandom);
      step();
      check("wr_mem_wren_a", 32'(mem_wren_a), 1);
      check("wr_mem_addr_a", 32'(mem_addr_a), i);
    end
    clear_inputs();
    wr_done = 1; rd_req = 1;
    step(); t_done = cyc; wr_done = 0;
    check("wr_enable_drop", 32'(wr_enable), 0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (rd_grant) got = 1;
    end
    check("grant_seen",    32'(got), 1);
    check("grant_latency", cyc - t_done, D + 1);
    for (int i = 0; i < 5; i++) begin
      rd_addr_a = AW'(i); rd_rden_a = 1;
      rd_addr_b = AW'($urandom); rd_rden_b = 1'($urandom);
      step();
      check("rd_mem_addr_a", 32'(mem_addr_a), i);
      check("rd_mem_rden_a", 32'(mem_rden_a), 1);
      check("rd_mem_wren_a", 32'(mem_wren_a), 0);
    end
    clear_inputs();
    rd_release = 1; step(); rd_release = 0;
    check("release_grant", 32'(rd_grant), 0);
    step();
    check("frame_cnt_1",   32'(frame_cnt), 1);
    check("no_collide",    32'(err_collide), 0);

    // ---------------- same-cycle events ----------------
    start = 1; step(); start = 0;
    wr_addr_a = AW'($urandom); wr_wren_a = 1; step(); wr_wren_a = 0;
    wr_done = 1; start = 1; step(); wr_done = 0;
    check("done_beats_start", 32'(wr_enable), 0);
    repeat (D + 2) step();   // start held through DRAIN and READY
    start = 0;
    check("start_ignored_wr", 32'(wr_enable), 0);
    check("start_ignored_rd", 32'(rd_grant),  0);
    rd_req = 1; step();
    check("grant_from_ready", 32'(rd_grant), 1);
    rd_release = 1; step();
    clear_inputs();
    check("release_beats_req", 32'(rd_grant), 0);
    step();
    check("frame_cnt_2", 32'(frame_cnt), 2);

    // ---------------- collision in READ ----------------
    start = 1; step(); start = 0;
    wr_done = 1; step(); wr_done = 0;
    rd_req = 1; repeat (D + 1) step(); rd_req = 0;
    check("coll_grant", 32'(rd_grant), 1);
    wr_addr_a = 7; wr_wren_a = 1; step(); wr_wren_a = 0;
    check("coll_blocked",  32'(mem_wren_a), 0);
    check("coll_flag",     32'(err_collide), 1);
    rd_release = 1; step(); rd_release = 0;
    step(); step();
    check("coll_sticky",   32'(err_collide), 1);
    check("frame_cnt_3",   32'(frame_cnt), 3);

    // ---------------- reset mid-DRAIN ----------------
    start = 1; step(); start = 0;
    wr_done = 1; step(); wr_done = 0;
    step();
    check("pre_reset_cnt", 32'(frame_cnt), 3);
    reset = 1; wr_wren_a = 1; wr_rden_b = 1; rd_rden_a = 1;
    wr_addr_a = AW'($urandom); rd_addr_b = AW'($urandom);
    step();
    clear_inputs();
    check("mid_rst_frame",   32'(frame_cnt), 0);
    check("mid_rst_collide", 32'(err_collide), 0);
    check("mid_rst_mem",     32'({mem_addr_a, mem_addr_b, mem_rden_a, mem_rden_b,
                                  mem_wren_a, mem_wren_b}), 0);
    rd_req = 1; repeat (D + 3) step(); rd_req = 0;
    check("mid_rst_no_grant", 32'(rd_grant), 0);
    start = 1; step(); start = 0;
    check("mid_rst_idle", 32'(wr_enable), 1);

    // ---------------- counter wrap ----------------
    reset = 1; step(); reset = 0;
    for (int f = 0; f < (1 << FW); f++) begin
      start = 1; step(); start = 0;
      wr_addr_a = AW'($urandom); wr_wren_a = 1'($urandom);
      wr_addr_b = AW'($urandom); wr_rden_b = 1'($urandom);
      wr_done = 1; step(); clear_inputs();
      rd_req = 1; repeat (D + 1) step();
      rd_addr_a = AW'($urandom); rd_rden_a = 1'($urandom);
      rd_release = 1; step(); clear_inputs();
      if (f == (1 << FW) - 2) check("frame_cnt_max", 32'(frame_cnt), (1 << FW) - 1);
    end
    check("frame_cnt_wrap", 32'(frame_cnt), 0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 3) == 0);
      wr_done    = ($urandom_range(0, 3) == 0);
      rd_req     = 1'($urandom);
      rd_release = ($urandom_range(0, 5) == 0);
      wr_addr_a  = AW'($urandom); wr_addr_b = AW'($urandom);
      rd_addr_a  = AW'($urandom); rd_addr_b = AW'($urandom);
      wr_rden_a  = ($urandom_range(0, 5) == 0); wr_rden_b = ($urandom_range(0, 5) == 0);
      wr_wren_a  = ($urandom_range(0, 5) == 0); wr_wren_b = ($urandom_range(0, 5) == 0);
      rd_rden_a  = ($urandom_range(0, 5) == 0); rd_rden_b = ($urandom_range(0, 5) == 0);
      step();
    end
    clear_inputs();

    // ---------------- read-ownership watchdog ----------------
    reset = 1; step(); reset = 0;
    start = 1; step(); start = 0;
    wr_done = 1; step(); wr_done = 0;
    rd_req = 1; repeat (D + 1) step(); rd_req = 0;
    check("wd_grant", 32'(rd_grant), 1);
    g = 1;
    for (int k = 0; k < 3 * TMO; k++) begin
      step();
      if (rd_grant) g++;
      else break;
    end
`ifdef POOL_ARB_TIMEOUT_EN
    check("wd_grant_cycles", g, TMO);
    check("wd_err_timeout",  32'(err_timeout), 1);
    check("wd_frame_cnt",    32'(frame_cnt), 0);
`else
    check("hold_grant",      32'(rd_grant), 1);
    check("hold_no_timeout", 32'(err_timeout), 0);
    check("hold_cycles",     g, 3 * TMO + 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
